// File: rtl/fft_mp_pkg.sv
// Shared types and helpers for the fft_multipoint frame streamer.
// Frame length is 256 points scaled by the np select.
package fft_mp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } stream_state_e;

  localparam int FFT_NP_MAX = 3;
  localparam int NP_W       = $clog2(FFT_NP_MAX + 1);

  function automatic int unsigned np_to_len(input logic [NP_W-1:0] np);
    return 32'd256 << np;
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The read register is not reset; the consumer masks it when idle.
module fft_frame_ram #(
  parameter int AW = 11,
  parameter int WW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [WW-1:0] rdata_o
);

  logic [WW-1:0] mem [2**AW];
  logic [WW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_streamer.sv
// Streams one stored frame into fft_multipoint with stb/sop framing, repeats and gaps,
// and checks valid/sop framing on the FFT output.
module fft_frame_streamer
  import fft_mp_pkg::*;
#(
  parameter int DW        = 16,
  parameter int MAX_LOG2N = 11,
  parameter int GAP_W     = 8,
  parameter int REP_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [MAX_LOG2N-1:0] wr_addr,
  input  logic [DW-1:0]        wr_re,
  input  logic [DW-1:0]        wr_im,
  input  logic                 start,
  input  logic [1:0]           np,
  input  logic [GAP_W-1:0]     gap,
  input  logic [REP_W-1:0]     reps,
  input  logic                 stop,
  output logic                 stb,
  output logic                 sop_in,
  output logic [DW-1:0]        x_re,
  output logic [DW-1:0]        x_im,
  output logic [1:0]           np_out,
  input  logic                 fft_valid,
  input  logic                 fft_sop,
  output logic                 busy,
  output logic                 done,
  output logic [REP_W-1:0]     frames_sent,
  output logic [REP_W-1:0]     frames_rcvd,
  output logic                 len_err
);

  localparam int LW = MAX_LOG2N + 1;

  stream_state_e        state_q, state_d;
  logic [MAX_LOG2N-1:0] idx_q, idx_d;
  logic [1:0]           np_q, np_d;
  logic [GAP_W-1:0]     gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [REP_W-1:0]     reps_q, reps_d;
  logic [REP_W-1:0]     frames_sent_q, frames_sent_d;
  logic [REP_W-1:0]     frames_rcvd_q, frames_rcvd_d;
  logic [LW-1:0]        rx_cnt_q, rx_cnt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 len_err_q, len_err_d;
  logic                 stb_q, stb_d, sop_q, sop_d, done_q, done_d;

  logic [LW-1:0]        n_len;
  logic [MAX_LOG2N-1:0] last_idx;
  logic                 accept;
  logic                 ram_we, ram_re;
  logic [2*DW-1:0]      rd_data;

  assign n_len    = LW'(np_to_len(np_q));
  assign last_idx = MAX_LOG2N'(n_len - LW'(1));
  assign accept   = (state_q == ST_IDLE) && start;
  // Host writes only land while idle, and never in the cycle that launches a frame.
  assign ram_we   = wr_en && (state_q == ST_IDLE) && !start;
  assign ram_re   = (state_d == ST_PLAY);

  fft_frame_ram #(
    .AW(MAX_LOG2N),
    .WW(2 * DW)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(wr_addr),
    .wdata_i({wr_re, wr_im}),
    .re_i   (ram_re),
    .raddr_i(idx_d),
    .rdata_o(rd_data)
  );

  // state_q describes what is on the output this cycle; idx_d is the address read for the next one.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    np_d          = np_q;
    gap_d         = gap_q;
    gap_cnt_d     = gap_cnt_q;
    reps_d        = reps_q;
    stop_pend_d   = stop_pend_q;
    frames_sent_d = frames_sent_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_PLAY;
          idx_d         = '0;
          np_d          = np;
          gap_d         = gap;
          reps_d        = reps;
          stop_pend_d   = 1'b0;
          frames_sent_d = '0;
        end
      end
      ST_PLAY: begin
        stop_pend_d = stop_pend_q | stop;
        if (idx_q == last_idx) begin
          frames_sent_d = frames_sent_q + REP_W'(1);
          idx_d         = '0;
          if (stop_pend_q || stop ||
              ((reps_q != '0) && ((frames_sent_q + REP_W'(1)) == reps_q))) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q;
          end
        end else begin
          idx_d = idx_q + MAX_LOG2N'(1);
        end
      end
      ST_GAP: begin
        stop_pend_d = stop_pend_q | stop;
        if (gap_cnt_q == GAP_W'(1)) begin
          if (stop_pend_q || stop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PLAY;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    stb_d = (state_d == ST_PLAY);
    sop_d = stb_d && (idx_d == '0);
  end

  always_comb begin
    rx_cnt_d      = rx_cnt_q;
    frames_rcvd_d = frames_rcvd_q;
    len_err_d     = len_err_q;
    if (fft_valid) begin
      if (fft_sop) begin
        if ((rx_cnt_q != '0) && (rx_cnt_q != n_len)) len_err_d = 1'b1;
        rx_cnt_d = LW'(1);
      end else if ((rx_cnt_q == '0) || (rx_cnt_q == n_len)) begin
        len_err_d = 1'b1;
      end else begin
        rx_cnt_d = rx_cnt_q + LW'(1);
      end
      if ((rx_cnt_d == n_len) && (rx_cnt_d != rx_cnt_q)) frames_rcvd_d = frames_rcvd_q + REP_W'(1);
    end
    // A new run restarts output framing from scratch since N may change.
    if (accept) begin
      rx_cnt_d      = '0;
      frames_rcvd_d = '0;
      len_err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      np_q          <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      reps_q        <= '0;
      stop_pend_q   <= 1'b0;
      frames_sent_q <= '0;
      frames_rcvd_q <= '0;
      rx_cnt_q      <= '0;
      len_err_q     <= 1'b0;
      stb_q         <= 1'b0;
      sop_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      np_q          <= np_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      reps_q        <= reps_d;
      stop_pend_q   <= stop_pend_d;
      frames_sent_q <= frames_sent_d;
      frames_rcvd_q <= frames_rcvd_d;
      rx_cnt_q      <= rx_cnt_d;
      len_err_q     <= len_err_d;
      stb_q         <= stb_d;
      sop_q         <= sop_d;
      done_q        <= done_d;
    end
  end

  assign stb         = stb_q;
  assign sop_in      = sop_q;
  assign x_re        = stb_q ? rd_data[2*DW-1:DW] : '0;
  assign x_im        = stb_q ? rd_data[DW-1:0]    : '0;
  assign np_out      = np_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign frames_sent = frames_sent_q;
  assign frames_rcvd = frames_rcvd_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Scoreboard bench for fft_frame_streamer: expected samples and done pulses are queued at
// stimulus time from a shadow RAM and frame-timing arithmetic; a negedge monitor compares.
module tb_fft_frame_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_re, wr_im;
  logic        start;
  logic [1:0]  np;
  logic [7:0]  gap, reps;
  logic        stop;
  logic        stb, sop_in;
  logic [15:0] x_re, x_im;
  logic [1:0]  np_out;
  logic        fft_valid, fft_sop;
  logic        busy, done;
  logic [7:0]  frames_sent, frames_rcvd;
  logic        len_err;

  fft_frame_streamer dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_re(wr_re), .wr_im(wr_im),
    .start(start), .np(np), .gap(gap), .reps(reps), .stop(stop),
    .stb(stb), .sop_in(sop_in), .x_re(x_re), .x_im(x_im), .np_out(np_out),
    .fft_valid(fft_valid), .fft_sop(fft_sop), .busy(busy), .done(done),
    .frames_sent(frames_sent), .frames_rcvd(frames_rcvd), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] re;
    logic [15:0] im;
    logic        sop;
    logic [1:0]  np;
  } exp_t;

  exp_t        exp_q[$];
  int          exp_done[$];
  logic [15:0] mem_re [2048];
  logic [15:0] mem_im [2048];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stb) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stb_unexpected: stb=1 x_re=%h at cycle %0d with nothing expected", x_re, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.re != x_re || e.im != x_im || e.sop != sop_in || e.np != np_out || !busy) begin
            errors++;
            $display("FAIL sample: got cyc=%0d re=%h im=%h sop=%0d np_out=%0d busy=%0d expected cyc=%0d re=%h im=%h sop=%0d np_out=%0d busy=1",
                     cyc, x_re, x_im, sop_in, np_out, busy, e.cyc, e.re, e.im, e.sop, e.np);
          end
        end
      end else begin
        checks++;
        if (x_re != 16'h0 || x_im != 16'h0 || sop_in) begin
          errors++;
          $display("FAIL idle_outputs: got x_re=%h x_im=%h sop=%0d expected all 0 (cycle %0d)", x_re, x_im, sop_in, cyc);
        end
      end
      if (done) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done=1 at cycle %0d with none expected", cyc);
        end else begin
          int dc;
          dc = exp_done.pop_front();
          if (dc != cyc || busy) begin
            errors++;
            $display("FAIL done: got cycle %0d busy=%0d expected cycle %0d busy=0", cyc, busy, dc);
          end
        end
      end
    end
  end

  task automatic wr(input int a, input logic [15:0] re, input logic [15:0] im);
    wr_en = 1'b1; wr_addr = 11'(a); wr_re = re; wr_im = im;
    tick();
    wr_en = 1'b0;
    mem_re[a] = re;
    mem_im[a] = im;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_done.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_done.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, expected 1", budget);
      exp_done.delete();
      exp_q.delete();
    end
  endtask

  // stop_f < 0: no stop. Otherwise stop pulses at position stop_s of period stop_f
  // (positions >= N fall in the following gap).
  task automatic play(input int npv, input int gapv, input int repv,
                      input int stop_f, input int stop_s, input bit poke_busy, input bit wr_in_start);
    int n, k0, frames, dcyc;
    n  = 256 << npv;
    k0 = cyc;
    frames = (stop_f >= 0) ? stop_f + 1 : repv;
    for (int f = 0; f < frames; f++)
      for (int s = 0; s < n; s++) begin
        exp_t e;
        e.cyc = k0 + 1 + f * (n + gapv) + s;
        e.re = mem_re[s]; e.im = mem_im[s]; e.sop = (s == 0); e.np = 2'(npv);
        exp_q.push_back(e);
      end
    if (stop_f >= 0 && stop_s >= n) dcyc = k0 + 1 + frames * (n + gapv);
    else                            dcyc = k0 + 1 + frames * n + (frames - 1) * gapv;
    exp_done.push_back(dcyc);

    np = 2'(npv); gap = 8'(gapv); reps = 8'(repv); start = 1'b1;
    if (wr_in_start) begin
      wr_en = 1'b1; wr_addr = 11'd3; wr_re = 16'hbeef; wr_im = 16'hcafe;
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    if (poke_busy) begin
      while (cyc < k0 + 1 + 10) tick();
      start = 1'b1; np = 2'(npv + 1); wr_en = 1'b1; wr_addr = 11'd5; wr_re = 16'hdead; wr_im = 16'hface;
      tick();
      start = 1'b0; wr_en = 1'b0;
    end
    if (stop_f >= 0) begin
      while (cyc < k0 + 1 + stop_f * (n + gapv) + stop_s) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    wait_done(frames * (n + gapv) + 50);
    tick();
    chk("frames_sent", int'(frames_sent), frames & 255);
    chk("busy_after_done", int'(busy), 0);
    chk("exp_leftover", exp_q.size(), 0);
  endtask

  task automatic burst(input int len);
    for (int i = 0; i < len; i++) begin
      fft_valid = 1'b1;
      fft_sop   = (i == 0);
      tick();
    end
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    tick();
  endtask

  initial begin
    int k0, m_err, m_rcvd, prev, len;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_re = '0; wr_im = '0;
    start = 1'b0; np = '0; gap = '0; reps = '0; stop = 1'b0;
    fft_valid = 1'b0; fft_sop = 1'b0;
    repeat (3) tick();
    chk("rst_stb", int'(stb), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_frames_sent", int'(frames_sent), 0);
    chk("rst_frames_rcvd", int'(frames_rcvd), 0);
    chk("rst_len_err", int'(len_err), 0);
    chk("rst_np_out", int'(np_out), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    for (int i = 0; i < 2048; i++) wr(i, 16'(i), 16'(-i));

    play(3, 0, 1, -1, 0, 1'b0, 1'b0);
    play(0, 5, 3, -1, 0, 1'b0, 1'b0);
    play(1, 0, 0, 1, 100, 1'b0, 1'b0);
    play(0, 4, 0, 0, 258, 1'b0, 1'b0);

    // start and a write while busy, plus a write in the start cycle: RAM must be untouched
    play(0, 0, 1, -1, 0, 1'b1, 1'b1);
    play(0, 0, 1, -1, 0, 1'b0, 1'b0);

    // reset one cycle while sample 700 of a 1024-point frame is on the output
    k0 = cyc;
    for (int s = 0; s <= 700; s++) begin
      exp_t e;
      e.cyc = k0 + 1 + s; e.re = mem_re[s]; e.im = mem_im[s]; e.sop = (s == 0); e.np = 2'd2;
      exp_q.push_back(e);
    end
    np = 2'd2; gap = 8'd0; reps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < k0 + 1 + 700) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_stb", int'(stb), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_x_re", int'(x_re), 0);
    chk("midrst_frames_sent", int'(frames_sent), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_np_out", int'(np_out), 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_leftover", exp_q.size(), 0);
    play(0, 0, 1, -1, 0, 1'b0, 1'b0);

    // random output framing against a burst-level model
    m_err = 0; m_rcvd = 0; prev = 0;
    for (int b = 0; b < 6; b++) begin
      len = (b == 5 || $urandom_range(0, 1) == 1) ? 256 : int'($urandom_range(1, 255));
      if (prev != 0 && prev != 256) m_err = 1;
      if (len == 256) m_rcvd++;
      prev = len;
      burst(len);
    end
    chk("rand_frames_rcvd", int'(frames_rcvd), m_rcvd);
    chk("rand_len_err", int'(len_err), m_err);

    play(0, 0, 1, -1, 0, 1'b0, 1'b0);
    chk("start_clears_len_err", int'(len_err), 0);
    chk("start_clears_rcvd", int'(frames_rcvd), 0);
    burst(256);
    chk("mon_rcvd_full", int'(frames_rcvd), 1);
    chk("mon_err_full", int'(len_err), 0);
    burst(255);
    burst(1);
    chk("mon_rcvd_short", int'(frames_rcvd), 1);
    chk("mon_err_short", int'(len_err), 1);
    play(0, 0, 1, -1, 0, 1'b0, 1'b0);
    chk("restart_clears_len_err", int'(len_err), 0);

    // random RAM contents and random run parameters
    for (int i = 0; i < 24; i++)
      wr($urandom_range(0, 511), 16'($urandom), 16'($urandom));
    for (int t = 0; t < 4; t++)
      play($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(1, 3), -1, 0, 1'b0, 1'b0);
    play(0, $urandom_range(1, 6), 0, $urandom_range(0, 2), $urandom_range(0, 255), 1'b0, 1'b0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
